rom_loader_ctrl: RTL and testbench

- Routes the ioctl byte stream from data_io into NPORTS SDRAM write ports. Each port owns an address window and uses a toggle req/ack handshake with a one-entry skid buffer.
- Generates the core's rom_loaded and core_reset. Reset is released only after every port has drained and a hold count has elapsed.
- Sits between data_io and sdram in an arcade top level. It replaces ad-hoc per-core edge-detect/toggle logic.

---
 rtl/rom_loader_pkg.sv | 24 ++
 rtl/rom_port_skid.sv | 109 ++++++++++
 rtl/rom_loader_ctrl.sv | 117 +++++++++++
 tb/tb_rom_loader_ctrl.sv | 358 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rom_loader_pkg.sv
// Shared types and helpers for the ROM loader: FSM state encoding and
// extraction of per-port fields from flattened parameter vectors.
package rom_loader_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StDrain,
    StHold,
    StRun
  } loader_state_e;

  localparam int unsigned MaxFlatW = 128;

  // Returns the aw-bit field idx of a flattened vector (field 0 in the LSBs).
  function automatic logic [31:0] slice_of(input logic [MaxFlatW-1:0] flat,
                                           input int unsigned aw,
                                           input int unsigned idx);
    logic [MaxFlatW-1:0] sh;
    sh = flat >> (aw * idx);
    return sh[31:0] & ((32'h1 << aw) - 32'h1);
  endfunction

endpackage

// File: rtl/rom_port_skid.sv
// One SDRAM write port: window hit, toggle req/ack issue and a one-entry
// skid buffer. Emits a one-cycle pulse whenever a byte has to be dropped.
module rom_port_skid #(
  parameter int unsigned   AW   = 25,
  parameter logic [AW-1:0] Base = '0,
  parameter logic [AW-1:0] Size = '0
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          wr_i,
  input  logic [AW-1:0] addr_i,
  input  logic [7:0]    data_i,
  input  logic          ack_i,
  output logic          req_o,
  output logic [AW-3:0] a_o,
  output logic [1:0]    ds_o,
  output logic [15:0]   d_o,
  output logic          busy_o,
  output logic          overrun_o
);

  logic [AW:0]   addr_x, lo_x, hi_x;
  logic [AW-1:0] off;
  logic [AW-3:0] cur_a;
  logic [1:0]    cur_ds;
  logic          hit, pending, unused_off;

  logic          req_q, req_d, hv_q, hv_d;
  logic [AW-3:0] a_q, a_d, ha_q, ha_d;
  logic [1:0]    ds_q, ds_d, hds_q, hds_d;
  logic [15:0]   d_q, d_d;
  logic [7:0]    hd_q, hd_d;

  // One extra bit keeps base + size from wrapping at the top of the space.
  assign addr_x     = {1'b0, addr_i};
  assign lo_x       = {1'b0, Base};
  assign hi_x       = lo_x + {1'b0, Size};
  assign hit        = wr_i & (addr_x >= lo_x) & (addr_x < hi_x);
  assign off        = addr_i - Base;
  assign cur_a      = off[AW-2:1];
  assign cur_ds     = {addr_i[0], ~addr_i[0]};
  assign unused_off = off[AW-1] ^ off[0];
  assign pending    = req_q ^ ack_i;

  always_comb begin
    req_d     = req_q;
    a_d       = a_q;
    ds_d      = ds_q;
    d_d       = d_q;
    hv_d      = hv_q;
    ha_d      = ha_q;
    hds_d     = hds_q;
    hd_d      = hd_q;
    overrun_o = 1'b0;
    if (!pending && hv_q) begin
      req_d = ~req_q;
      a_d   = ha_q;
      ds_d  = hds_q;
      d_d   = {hd_q, hd_q};
      hv_d  = 1'b0;
    end
    if (hit) begin
      if (!pending && !hv_q) begin
        req_d = ~req_q;
        a_d   = cur_a;
        ds_d  = cur_ds;
        d_d   = {data_i, data_i};
      end else if (pending && hv_q) begin
        overrun_o = 1'b1;
      end else begin
        // Either still waiting on sdram, or the hold slot is being drained
        // this cycle: the new byte queues behind it.
        hv_d  = 1'b1;
        ha_d  = cur_a;
        hds_d = cur_ds;
        hd_d  = data_i;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      req_q <= 1'b0;
      a_q   <= '0;
      ds_q  <= '0;
      d_q   <= '0;
      hv_q  <= 1'b0;
      ha_q  <= '0;
      hds_q <= '0;
      hd_q  <= '0;
    end else begin
      req_q <= req_d;
      a_q   <= a_d;
      ds_q  <= ds_d;
      d_q   <= d_d;
      hv_q  <= hv_d;
      ha_q  <= ha_d;
      hds_q <= hds_d;
      hd_q  <= hd_d;
    end
  end

  assign req_o  = req_q;
  assign a_o    = a_q;
  assign ds_o   = ds_q;
  assign d_o    = d_q;
  assign busy_o = pending | hv_q;

endmodule

// File: rtl/rom_loader_ctrl.sv
// Routes the ioctl ROM byte stream into NPORTS SDRAM write ports and
// sequences rom_loaded / core_reset around the download.
module rom_loader_ctrl
  import rom_loader_pkg::*;
#(
  parameter int unsigned             NPORTS     = 2,
  parameter int unsigned             AW         = 25,
  parameter logic [NPORTS*AW-1:0]    PORT_BASE  = {25'h40000, 25'h0},
  parameter logic [NPORTS*AW-1:0]    PORT_SIZE  = {25'h40000, 25'h40000},
  parameter logic [7:0]              ROM_INDEX  = 8'h00,
  parameter int unsigned             RESET_HOLD = 16
) (
  input  logic                     clk_sys,
  input  logic                     reset,
  input  logic                     ioctl_downl,
  input  logic [7:0]               ioctl_index,
  input  logic                     ioctl_wr,
  input  logic [AW-1:0]            ioctl_addr,
  input  logic [7:0]               ioctl_dout,
  input  logic                     user_reset,
  output logic [NPORTS-1:0]        port_req,
  input  logic [NPORTS-1:0]        port_ack,
  output logic [NPORTS*(AW-2)-1:0] port_a,
  output logic [NPORTS*2-1:0]      port_ds,
  output logic [NPORTS*16-1:0]     port_d,
  output logic                     port_we,
  output logic                     rom_loaded,
  output logic                     core_reset,
  output logic                     overrun
);

  localparam int unsigned CntW = (RESET_HOLD > 1) ? $clog2(RESET_HOLD) : 1;

  logic              act, wr_edge, port_wr, all_idle, any_ovr;
  logic [NPORTS-1:0] busy, ovr_pulse;

  loader_state_e state_q;
  logic [CntW-1:0] cnt_q;
  logic wr_last_q, we_q, rom_loaded_q, core_reset_q, overrun_q;

  assign act      = ioctl_downl & (ioctl_index == ROM_INDEX);
  assign wr_edge  = ioctl_wr & ~wr_last_q;
  assign port_wr  = wr_edge & act;
  assign all_idle = ~|busy;
  assign any_ovr  = |ovr_pulse;

  for (genvar g = 0; g < NPORTS; g++) begin : g_port
    rom_port_skid #(
      .AW   (AW),
      .Base (AW'(slice_of(MaxFlatW'(PORT_BASE), AW, g))),
      .Size (AW'(slice_of(MaxFlatW'(PORT_SIZE), AW, g)))
    ) u_port (
      .clk_i     (clk_sys),
      .rst_i     (reset),
      .wr_i      (port_wr),
      .addr_i    (ioctl_addr),
      .data_i    (ioctl_dout),
      .ack_i     (port_ack[g]),
      .req_o     (port_req[g]),
      .a_o       (port_a[g*(AW-2) +: (AW-2)]),
      .ds_o      (port_ds[g*2 +: 2]),
      .d_o       (port_d[g*16 +: 16]),
      .busy_o    (busy[g]),
      .overrun_o (ovr_pulse[g])
    );
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      wr_last_q    <= 1'b0;
      we_q         <= 1'b0;
      rom_loaded_q <= 1'b0;
      core_reset_q <= 1'b1;
      overrun_q    <= 1'b0;
    end else begin
      wr_last_q    <= ioctl_wr;
      we_q         <= act;
      core_reset_q <= (state_q != StRun) | user_reset;
      // Any state restarts the load when a ROM download (re)appears.
      if (act && state_q != StLoad) begin
        state_q      <= StLoad;
        rom_loaded_q <= 1'b0;
        overrun_q    <= 1'b0;
      end else begin
        unique case (state_q)
          StLoad: if (!act) state_q <= StDrain;
          StDrain: begin
            if (all_idle) begin
              cnt_q   <= CntW'(RESET_HOLD - 1);
              state_q <= StHold;
            end
          end
          StHold: begin
            if (cnt_q == '0) begin
              rom_loaded_q <= 1'b1;
              state_q      <= StRun;
            end else begin
              cnt_q <= cnt_q - 1'b1;
            end
          end
          StIdle, StRun: ;
          default: state_q <= StIdle;
        endcase
      end
      // A dropped byte is always reported, even on the cycle a load restarts.
      if (any_ovr) overrun_q <= 1'b1;
    end
  end

  assign port_we    = we_q;
  assign rom_loaded = rom_loaded_q;
  assign core_reset = core_reset_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_rom_loader_ctrl.sv
// Self-checking bench for rom_loader_ctrl: a scoreboard of expected SDRAM
// writes per port, filled as bytes are sent and drained on each req toggle.
module tb_rom_loader_ctrl;

  localparam int unsigned NP  = 2;
  localparam int unsigned AW  = 25;
  localparam int unsigned AWW = AW - 2;
  localparam logic [24:0] WIN = 25'h40000;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            ioctl_downl = 1'b0;
  logic [7:0]      ioctl_index = 8'h00;
  logic            ioctl_wr = 1'b0;
  logic [AW-1:0]   ioctl_addr = '0;
  logic [7:0]      ioctl_dout = 8'h00;
  logic            user_reset = 1'b0;
  logic [NP-1:0]   port_req;
  logic [NP-1:0]   port_ack = '0;
  logic [NP*AWW-1:0] port_a;
  logic [NP*2-1:0] port_ds;
  logic [NP*16-1:0] port_d;
  logic            port_we, rom_loaded, core_reset, overrun;

  typedef struct packed {
    logic [AWW-1:0] a;
    logic [1:0]     ds;
    logic [15:0]    d;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int tests_run = 0;
  int failures = 0;
  logic [NP-1:0] prev_req = '0;
  logic [NP-1:0] withhold = '0;
  bit rand_ack = 1'b0;
  int ack_cnt [NP] = '{0, 0};
  int ack_dly [NP] = '{3, 3};

  always #5 clk = ~clk;

  rom_loader_ctrl #(
    .NPORTS     (2),
    .AW         (25),
    .PORT_BASE  ({25'h40000, 25'h0}),
    .PORT_SIZE  ({25'h40000, 25'h40000}),
    .ROM_INDEX  (8'h00),
    .RESET_HOLD (16)
  ) dut (
    .clk_sys     (clk),
    .reset       (reset),
    .ioctl_downl (ioctl_downl),
    .ioctl_index (ioctl_index),
    .ioctl_wr    (ioctl_wr),
    .ioctl_addr  (ioctl_addr),
    .ioctl_dout  (ioctl_dout),
    .user_reset  (user_reset),
    .port_req    (port_req),
    .port_ack    (port_ack),
    .port_a      (port_a),
    .port_ds     (port_ds),
    .port_d      (port_d),
    .port_we     (port_we),
    .rom_loaded  (rom_loaded),
    .core_reset  (core_reset),
    .overrun     (overrun)
  );

  // SDRAM side: acknowledges each request after ack_dly negedges unless held.
  always @(negedge clk) begin
    for (int p = 0; p < NP; p++) begin
      if (reset) begin
        port_ack[p] = 1'b0;
        ack_cnt[p]  = 0;
      end else if (port_req[p] !== port_ack[p]) begin
        ack_cnt[p] = ack_cnt[p] + 1;
        if (!withhold[p] && ack_cnt[p] >= ack_dly[p]) begin
          port_ack[p] = port_req[p];
          ack_cnt[p]  = 0;
          ack_dly[p]  = rand_ack ? int'($urandom_range(1, 6)) : 3;
        end
      end
    end
  end

  task automatic check_toggles();
    exp_t e, got;
    for (int p = 0; p < NP; p++) begin
      if (!reset && port_req[p] !== prev_req[p]) begin
        tests_run++;
        got.a  = port_a[p*AWW +: AWW];
        got.ds = port_ds[p*2 +: 2];
        got.d  = port_d[p*16 +: 16];
        if ((p == 0 && q0.size() == 0) || (p == 1 && q1.size() == 0)) begin
          failures++;
          $display("FAIL unexpected_toggle port%0d: got a=%h ds=%b d=%h, required no toggle",
                   p, got.a, got.ds, got.d);
        end else begin
          if (p == 0) e = q0.pop_front();
          else e = q1.pop_front();
          if (got !== e) begin
            failures++;
            $display("FAIL write_port%0d: got a=%h ds=%b d=%h, required a=%h ds=%b d=%h",
                     p, got.a, got.ds, got.d, e.a, e.ds, e.d);
          end
        end
      end
    end
    prev_req = port_req;
  endtask

  task automatic step();
    @(negedge clk);
    check_toggles();
    #1;
  endtask

  task automatic send_byte(input logic [24:0] addr, input logic [7:0] data,
                           input bit expect_en, input int gap);
    exp_t e;
    logic [25:0] base;
    if (expect_en) begin
      for (int p = 0; p < NP; p++) begin
        base = (p == 0) ? 26'h0 : 26'h40000;
        if ({1'b0, addr} >= base && {1'b0, addr} < base + {1'b0, WIN}) begin
          e.a  = AWW'(({1'b0, addr} - base) >> 1);
          e.ds = {addr[0], ~addr[0]};
          e.d  = {data, data};
          if (p == 0) q0.push_back(e);
          else q1.push_back(e);
        end
      end
    end
    ioctl_addr = addr;
    ioctl_dout = data;
    ioctl_wr   = 1'b1;
    step();
    ioctl_wr = 1'b0;
    step();
    repeat (gap) step();
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while ((q0.size() != 0 || q1.size() != 0 || port_req !== port_ack) && n < 300) begin
      step();
      n++;
    end
    tests_run++;
    if (q0.size() != 0 || q1.size() != 0 || port_req !== port_ack) begin
      failures++;
      $display("FAIL %s_drain: got %0d/%0d writes outstanding req=%b ack=%b, required 0/0",
               name, q0.size(), q1.size(), port_req, port_ack);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) step();
    tests_run += 3;
    if (port_req !== 2'b00) begin failures++; $display("FAIL rst_req: got %b, required 00", port_req); end
    if ({core_reset, rom_loaded, overrun, port_we} !== 4'b1000) begin
      failures++;
      $display("FAIL rst_flags: got %b, required 1000", {core_reset, rom_loaded, overrun, port_we});
    end
    if (port_a !== '0 || port_ds !== '0 || port_d !== '0) begin
      failures++;
      $display("FAIL rst_data: got a=%h ds=%h d=%h, required 0", port_a, port_ds, port_d);
    end
    reset = 1'b0;
    repeat (3) step();
    tests_run++;
    if (core_reset !== 1'b1) begin failures++; $display("FAIL idle_core_reset: got %b, required 1", core_reset); end
  endtask

  task automatic test_single_byte();
    ioctl_index = 8'h00;
    ioctl_downl = 1'b1;
    step();
    step();
    tests_run++;
    if (port_we !== 1'b1) begin failures++; $display("FAIL port_we_load: got %b, required 1", port_we); end
    send_byte(25'h00005, 8'hA5, 1'b1, 2);
    wait_drain("single");
    tests_run += 2;
    if (port_req !== 2'b01) begin failures++; $display("FAIL single_req: got %b, required 01", port_req); end
    if ({port_a[AWW-1:0], port_ds[1:0], port_d[15:0]} !== {23'd2, 2'b10, 16'hA5A5}) begin
      failures++;
      $display("FAIL single_data: got a=%h ds=%b d=%h, required a=2 ds=10 d=a5a5",
               port_a[AWW-1:0], port_ds[1:0], port_d[15:0]);
    end
  endtask

  task automatic test_windows();
    send_byte(25'h40001, 8'h3C, 1'b1, 2);
    send_byte(25'h80000, 8'h77, 1'b1, 2);
    wait_drain("window");
    tests_run += 2;
    if (port_req !== 2'b11) begin failures++; $display("FAIL window_req: got %b, required 11", port_req); end
    if ({port_a[2*AWW-1:AWW], port_ds[3:2], port_d[31:16]} !== {23'd0, 2'b10, 16'h3C3C}) begin
      failures++;
      $display("FAIL window_data: got a=%h ds=%b d=%h, required a=0 ds=10 d=3c3c",
               port_a[2*AWW-1:AWW], port_ds[3:2], port_d[31:16]);
    end
  endtask

  task automatic test_overrun();
    int n;
    withhold[0] = 1'b1;
    send_byte(25'h00010, 8'h11, 1'b1, 0);
    send_byte(25'h00011, 8'h22, 1'b1, 0);
    send_byte(25'h00012, 8'h33, 1'b0, 0);
    repeat (20) step();
    tests_run += 2;
    if (overrun !== 1'b1) begin failures++; $display("FAIL overrun_set: got %b, required 1", overrun); end
    if ((port_req[0] ^ port_ack[0]) !== 1'b1) begin
      failures++;
      $display("FAIL overrun_pending: got %b, required 1", port_req[0] ^ port_ack[0]);
    end
    ioctl_downl = 1'b0;
    repeat (5) step();
    tests_run++;
    if ({rom_loaded, core_reset} !== 2'b01) begin
      failures++;
      $display("FAIL drain_blocked: got %b, required 01", {rom_loaded, core_reset});
    end
    withhold[0] = 1'b0;
    step();
    tests_run++;
    if (port_req[0] !== port_ack[0]) begin failures++; $display("FAIL ack_seen: got req=%b ack=%b, required equal", port_req[0], port_ack[0]); end
    step();
    tests_run++;
    if (port_req[0] === port_ack[0]) begin failures++; $display("FAIL hold_issue_latency: got req=%b ack=%b, required differ", port_req[0], port_ack[0]); end
    wait_drain("overrun");
    n = 0;
    while (rom_loaded !== 1'b1 && n < 100) begin step(); n++; end
    step();
    step();
    tests_run++;
    if ({rom_loaded, core_reset} !== 2'b10) begin
      failures++;
      $display("FAIL load_done: got %b, required 10", {rom_loaded, core_reset});
    end
  endtask

  task automatic test_full_download();
    int k;
    rand_ack = 1'b1;
    ioctl_downl = 1'b1;
    step();
    step();
    tests_run++;
    if ({overrun, rom_loaded, core_reset} !== 3'b001) begin
      failures++;
      $display("FAIL reload_entry: got %b, required 001", {overrun, rom_loaded, core_reset});
    end
    for (int i = 0; i < 128; i++) begin
      send_byte(25'(i), 8'($urandom), 1'b1, 8);
      send_byte(25'(32'h40000 + i), 8'($urandom), 1'b1, 8);
    end
    send_byte(25'h3FFFF, 8'hE1, 1'b1, 8);
    send_byte(25'h7FFFF, 8'hE2, 1'b1, 8);
    send_byte(25'h80000, 8'hE3, 1'b1, 8);
    wait_drain("full");
    ioctl_downl = 1'b0;
    k = 0;
    while (rom_loaded !== 1'b1 && k < 100) begin step(); k++; end
    tests_run += 2;
    if (k !== 18 || core_reset !== 1'b1) begin
      failures++;
      $display("FAIL hold_time: got %0d cycles core_reset=%b, required 18 cycles core_reset=1", k, core_reset);
    end
    step();
    if ({core_reset, overrun} !== 2'b00) begin
      failures++;
      $display("FAIL release: got %b, required 00", {core_reset, overrun});
    end
    user_reset = 1'b1;
    step();
    step();
    tests_run++;
    if ({core_reset, rom_loaded} !== 2'b11) begin
      failures++;
      $display("FAIL user_reset: got %b, required 11", {core_reset, rom_loaded});
    end
    user_reset = 1'b0;
    step();
    step();
    tests_run++;
    if (core_reset !== 1'b0) begin failures++; $display("FAIL user_release: got %b, required 0", core_reset); end
    rand_ack = 1'b0;
  endtask

  task automatic test_other_index();
    ioctl_index = 8'h01;
    ioctl_downl = 1'b1;
    step();
    for (int i = 0; i < 4; i++) send_byte(25'(i * 3), 8'(i + 1), 1'b0, 2);
    tests_run += 2;
    if ({core_reset, rom_loaded, port_we} !== 3'b010) begin
      failures++;
      $display("FAIL other_index: got %b, required 010", {core_reset, rom_loaded, port_we});
    end
    if (port_req !== port_ack) begin failures++; $display("FAIL other_index_req: got req=%b ack=%b, required equal", port_req, port_ack); end
    ioctl_downl = 1'b0;
    ioctl_index = 8'h00;
    step();
  endtask

  task automatic test_reset_mid_load();
    ioctl_downl = 1'b1;
    step();
    step();
    withhold[0] = 1'b1;
    send_byte(25'h00020, 8'h5A, 1'b1, 2);
    tests_run++;
    if ((port_req[0] ^ port_ack[0]) !== 1'b1) begin
      failures++;
      $display("FAIL mid_pending: got %b, required 1", port_req[0] ^ port_ack[0]);
    end
    reset = 1'b1;
    #1;
    tests_run += 2;
    if (port_req !== 2'b00 || port_a !== '0 || port_d !== '0) begin
      failures++;
      $display("FAIL async_rst_port: got req=%b a=%h d=%h, required 0", port_req, port_a, port_d);
    end
    if ({core_reset, rom_loaded, overrun, port_we} !== 4'b1000) begin
      failures++;
      $display("FAIL async_rst_flags: got %b, required 1000", {core_reset, rom_loaded, overrun, port_we});
    end
    ioctl_downl = 1'b0;
    withhold = '0;
    step();
    step();
    reset = 1'b0;
    repeat (4) step();
    tests_run++;
    if ({core_reset, port_req} !== 3'b100) begin
      failures++;
      $display("FAIL post_rst_idle: got %b, required 100", {core_reset, port_req});
    end
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_windows();
    test_overrun();
    test_full_download();
    test_other_index();
    test_reset_mid_load();
    $display("[TB] %0d tests run, %0d failed", tests_run, failures);
    $finish;
  end

endmodule
